// File: rtl/power_accum.sv
// Averaged instantaneous power |I+jQ|^2 over windows of 2^AVG_LOG2 valid samples.
// Three register stages: square, sum, accumulate/emit.
module power_accum #(
    parameter int AVG_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic signed [15:0] i_data,
    input  logic signed [15:0] q_data,
    input  logic               clr,
    output logic               valid_out,
    output logic        [31:0] power
);

    localparam int DATA_W = 16;
    localparam int SQ_W   = 2 * DATA_W - 1;
    localparam int SUM_W  = 2 * DATA_W;
    localparam int ACC_W  = SUM_W + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    // Truncating mean: the window length is a power of two, so a shift suffices.
    // The shifted value never exceeds 2^31, so dropping the upper bits is exact.
    function automatic logic [31:0] mean_trunc(input logic [ACC_W-1:0] s);
        return 32'(s >> AVG_LOG2);
    endfunction

    logic        [SQ_W-1:0]  i_sq, q_sq;
    logic        [SQ_W-1:0]  sq_i_p0, sq_q_p0;
    logic                    vld_p0;
    logic        [SUM_W-1:0] sum_p1;
    logic                    vld_p1;
    logic        [ACC_W-1:0] acc;
    logic        [ACC_W-1:0] acc_sum;
    logic        [CNT_W-1:0] cnt;
    logic                    win_last;

    // A square of a 16-bit signed value is at most 2^30, so 31 bits hold it unsigned.
    assign i_sq     = SQ_W'(32'(i_data) * 32'(i_data));
    assign q_sq     = SQ_W'(32'(q_data) * 32'(q_data));
    assign acc_sum  = acc + ACC_W'(sum_p1);
    assign win_last = (cnt == CNT_LAST);

    // Stage 1 -> stage 2 data path
    always_ff @(posedge clk) begin
        if (valid_in) begin
            sq_i_p0 <= i_sq;
            sq_q_p0 <= q_sq;
        end
        if (vld_p0) begin
            sum_p1 <= SUM_W'(sq_i_p0) + SUM_W'(sq_q_p0);
        end
    end

    // Stage 3: window accumulation, plus pipeline valid tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            power     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (clr) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                cnt    <= '0;
                acc    <= '0;
            end else begin
                vld_p0 <= valid_in;
                vld_p1 <= vld_p0;
                if (vld_p1) begin
                    if (win_last) begin
                        power     <= mean_trunc(acc_sum);
                        valid_out <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_power_accum.sv
// Bench for power_accum: two instances (window 1 and window 16) share stimulus and
// are checked every cycle against a window-level reference model.
module tb_power_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic               clr = 1'b0;
    logic signed [15:0] i_d = '0;
    logic signed [15:0] q_d = '0;
    logic               vo0, vo4;
    logic        [31:0] pw0, pw4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    power_accum #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .i_data(i_d), .q_data(q_d),
        .clr(clr), .valid_out(vo0), .power(pw0)
    );

    power_accum #(.AVG_LOG2(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .i_data(i_d), .q_data(q_d),
        .clr(clr), .valid_out(vo4), .power(pw4)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: a sample presented at edge e joins a window at edge e+2
    // unless clr or rst is seen at e, e+1 or e+2.
    localparam int WIN [2] = '{1, 16};
    int     e = 0;
    bit     hv [4];
    bit     hk [4];
    longint hs [4];
    longint msum [2];
    int     mcnt [2];
    longint mpow [2];
    bit     mpulse [2];

    always @(posedge clk) begin
        longint s;
        hv[e % 4] = valid_in;
        hk[e % 4] = clr | rst;
        hs[e % 4] = longint'(i_d) * longint'(i_d) + longint'(q_d) * longint'(q_d);
        for (int m = 0; m < 2; m++) mpulse[m] = 1'b0;
        if (rst || clr) begin
            for (int m = 0; m < 2; m++) begin
                mcnt[m] = 0;
                msum[m] = 0;
                if (rst) mpow[m] = 0;
            end
        end else if (e >= 2 && hv[(e - 2) % 4] && !hk[(e - 2) % 4] && !hk[(e - 1) % 4]) begin
            s = hs[(e - 2) % 4];
            for (int m = 0; m < 2; m++) begin
                msum[m] += s;
                mcnt[m]++;
                if (mcnt[m] == WIN[m]) begin
                    mpow[m]   = msum[m] / WIN[m];
                    mpulse[m] = 1'b1;
                    mcnt[m]   = 0;
                    msum[m]   = 0;
                end
            end
        end
        e++;
    end

    always @(negedge clk) begin
        chk("vo_n1",  vo0, rst ? 0 : longint'(mpulse[0]));
        chk("pw_n1",  pw0, rst ? 0 : mpow[0]);
        chk("vo_n16", vo4, rst ? 0 : longint'(mpulse[1]));
        chk("pw_n16", pw4, rst ? 0 : mpow[1]);
    end

    task automatic step(input logic v, input logic signed [15:0] i, input logic signed [15:0] q,
                        input logic c, input logic r);
        @(posedge clk);
        #1;
        valid_in = v;
        i_d      = i;
        q_d      = q;
        clr      = c;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic prep();
        step(1'b0, 16'sd0, 16'sd0, 1'b1, 1'b0);
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
    endtask

    // mode 0: constant, mode 1: odd steps carry (0,0), mode 2: odd steps invalid
    task automatic run(input int n, input int mode, input logic signed [15:0] ia,
                       input logic signed [15:0] qa, output int first, output int np);
        logic               v;
        logic signed [15:0] i, q;
        first = -1;
        np    = 0;
        for (int k = 0; k < n; k++) begin
            v = 1'b1;
            i = ia;
            q = qa;
            if (mode == 1 && (k % 2) == 1) begin
                i = '0;
                q = '0;
            end
            if (mode == 2 && (k % 2) == 1) v = 1'b0;
            step(v, i, q, 1'b0, 1'b0);
            if (vo4) begin
                np++;
                if (first < 0) first = k;
            end
        end
    endtask

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        longint             exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int f, np;
        tbl[0] = '{16'sd1000,   16'sd0,      64'd1000000};
        tbl[1] = '{-16'sd32768, -16'sd32768, 64'd2147483648};
        tbl[2] = '{16'sd3,      16'sd4,      64'd25};
        tbl[3] = '{-16'sd1,     16'sd1,      64'd2};
        tbl[4] = '{16'sd0,      16'sd0,      64'd0};
        tbl[5] = '{16'sd32767,  -16'sd32768, 64'd2147418113};
        tbl[6] = '{-16'sd32768, 16'sd0,      64'd1073741824};
        tbl[7] = '{-16'sd300,   -16'sd400,   64'd250000};

        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
        chk("reset_pw", pw4, 0);
        chk("reset_vo", vo4, 0);
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);

        // Window of one: every sample emerges three cycles later as I^2+Q^2
        for (int k = 0; k < 11; k++) begin
            if (k < 8) step(1'b1, tbl[k].i, tbl[k].q, 1'b0, 1'b0);
            else       step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);
            if (k >= 3) begin
                chk("tbl_pw", pw0, tbl[k - 3].exp);
                chk("tbl_vo", vo0, 1);
            end
        end

        prep();
        run(40, 0, 16'sd1000, 16'sd0, f, np);
        chk("const_first", f, 18);
        chk("const_npulse", np, 2);
        chk("const_pw", pw4, 1000000);

        prep();
        run(20, 0, -16'sd32768, -16'sd32768, f, np);
        chk("max_first", f, 18);
        chk("max_pw", pw4, 64'h80000000);

        prep();
        run(20, 1, 16'sd3, 16'sd4, f, np);
        chk("alt_first", f, 18);
        chk("alt_pw", pw4, 12);

        prep();
        run(36, 2, 16'sd100, 16'sd100, f, np);
        chk("gap_first", f, 33);
        chk("gap_npulse", np, 1);
        chk("gap_pw", pw4, 20000);

        prep();
        run(8, 0, 16'sd7, 16'sd0, f, np);
        chk("clr_pre_np", np, 0);
        step(1'b1, 16'sd7, 16'sd0, 1'b1, 1'b0);
        chk("clr_hold_pw", pw4, 20000);
        chk("clr_vo", vo4, 0);
        run(15, 0, 16'sd10, 16'sd0, f, np);
        chk("clr_mid_np", np, 0);
        chk("clr_mid_pw", pw4, 20000);
        run(5, 0, 16'sd10, 16'sd0, f, np);
        chk("clr_first", f, 3);
        chk("clr_pw", pw4, 100);

        prep();
        run(10, 0, 16'sd5, 16'sd5, f, np);
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
        chk("rst_pw", pw4, 0);
        chk("rst_vo", vo4, 0);
        chk("rst_pw_n1", pw0, 0);
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1);
        step(1'b1, 16'sd10, 16'sd10, 1'b0, 1'b0);
        run(18, 0, 16'sd10, 16'sd10, f, np);
        chk("rst_first", f, 17);
        chk("rst_npulse", np, 1);
        chk("rst_after_pw", pw4, 200);

        for (int k = 0; k < 700; k++) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
                 ($urandom % 60) == 0, ($urandom % 250) == 0);
        end
        step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/power_accum.md
POWER_ACCUM -- requirements
Module: power_accum

Interface
REQ-001 Parameter AVG_LOG2, default 4, log2 of the averaging window length N = 2^AVG_LOG2; legal range 0..10.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 valid_in  input  1  qualifies i_data/q_data in the current cycle.
REQ-005 i_data  input  16  signed two's-complement in-phase sample.
REQ-006 q_data  input  16  signed two's-complement quadrature sample.
REQ-007 clr  input  1  synchronous abort of the current window and the pipeline contents.
REQ-008 valid_out  output  1  single-cycle pulse marking a new power result.
REQ-009 power  output  32  unsigned mean of I^2+Q^2 over N samples; feeds log_calc.power directly.

Function
REQ-010 Stage 1 SHALL register i_data*i_data and q_data*q_data as 31-bit unsigned products, tagged with a stage-1 valid bit.
REQ-011 Stage 2 SHALL register the 32-bit unsigned sum of the two squares; the maximum value is 2^31, and no wrap is permitted.
REQ-012 Stage 3 SHALL add each stage-2-valid sum into an accumulator of width 32+AVG_LOG2, counting samples with a counter of width max(AVG_LOG2,1).
REQ-013 Only cycles with valid_in=1 SHALL enter the pipeline; gaps in valid_in SHALL neither advance the counter nor alter the accumulator.
REQ-014 When the N-th valid sample of a window reaches stage 3, the block SHALL load power with (accumulator + that sample) >> AVG_LOG2, truncated rather than rounded.
REQ-015 In that same cycle the block SHALL assert valid_out for exactly one cycle.
REQ-016 In that same cycle the accumulator SHALL be loaded with 0 and the counter with 0, so that no sample is dropped between consecutive windows.
REQ-017 Latency SHALL be 3 cycles: the N-th valid_in sample at edge t produces valid_out=1 and the new power value after edge t+3.
REQ-018 power SHALL hold its last value between pulses.
REQ-019 valid_out SHALL be 0 in every cycle that does not complete a window.
REQ-020 When AVG_LOG2=0, every valid sample SHALL produce a result, 3 cycles later, with power equal to I^2+Q^2.
REQ-021 clr=1 at an edge SHALL zero the accumulator, the counter and all pipeline valid bits.
REQ-022 clr SHALL suppress any valid_out that would otherwise be produced at that edge.
REQ-023 clr SHALL leave power unchanged.
REQ-024 clr SHALL take priority over a simultaneous valid_in, and the sample presented in that cycle SHALL be discarded.
REQ-025 Accumulating N samples of value 2^31 SHALL not overflow the 32+AVG_LOG2-bit accumulator.
REQ-026 The shifted result SHALL always fit in 32 bits; no saturation logic is required.
REQ-027 Internal state SHALL be: counter, accumulator, two pipeline data registers and two pipeline valid bits. No other state machine is permitted.

Reset
REQ-028 While rst=1, the block SHALL immediately force valid_out=0, power=0, accumulator=0, counter=0 and all pipeline valid bits to 0.
REQ-029 Reset asserted mid-window SHALL discard all partial-window samples; the first window after release SHALL start at sample 1.
REQ-030 The first edge after rst deasserts SHALL accept a valid sample.

Verification
REQ-031 AVG_LOG2=4, I=1000, Q=0, valid_in held at 1 -> first valid_out 3 cycles after the 16th sample, power=1_000_000, then one pulse every 16 cycles.
REQ-032 AVG_LOG2=4, I=Q=-32768 continuously -> power=2_147_483_648 (0x80000000), no wrap.
REQ-033 AVG_LOG2=4, alternating samples (3,4) and (0,0) -> power=12, i.e. 200/16 truncated.
REQ-034 AVG_LOG2=4, valid_in high on alternate cycles, I=100, Q=100 -> pulse only after 16 valid samples, about 32 cycles, power=20_000.
REQ-035 After 8 samples assert clr for one cycle (valid_in=1 in that cycle), then 16 samples of I=10, Q=0 -> no pulse before the 16th post-clr sample, power=100, and the prior power is held until then.
REQ-036 Assert rst for 2 cycles after 10 samples of a window -> valid_out=0 and power=0 immediately, and the next pulse occurs only after 16 fresh samples.
